// File: rtl/chunk_adder_pkg.sv
// Shared definitions for the multi-cycle wide adder: FSM encoding and sizing helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-wide slices that make up a WIDTH-wide operand.
    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Slice-index counter width; never narrower than one bit so a
    // single-slice configuration still has a legal counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit Kogge-Stone adder with carry-in and carry-out.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs follow the inputs.
//
// Ports:
//   a, b  - CHUNK-bit addends
//   cin   - carry into bit 0
//   sum   - a + b + cin, low CHUNK bits
//   cout  - carry out of bit CHUNK-1
module chunk_adder
    import chunk_adder_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = (CHUNK > 1) ? $clog2(CHUNK) : 0;

    logic [CHUNK-1:0] prop;
    logic [CHUNK-1:0] gen_pfx;
    logic [CHUNK-1:0] prop_pfx;
    logic [CHUNK-1:0] carry_vec;

    always_comb begin
        prop     = a ^ b;
        gen_pfx  = a & b;
        // Fold the carry-in into bit 0's generate so every prefix group
        // already accounts for it; gen_pfx[i] then is the carry into bit i+1.
        gen_pfx[0] = gen_pfx[0] | (prop[0] & cin);
        prop_pfx = prop;

        // In-place prefix levels. Walking i downwards means gen_pfx[i-d] and
        // prop_pfx[i-d] still hold the previous level's values when read.
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = CHUNK - 1; i >= (1 << l); i--) begin
                gen_pfx[i]  = gen_pfx[i] | (prop_pfx[i] & gen_pfx[i - (1 << l)]);
                prop_pfx[i] = prop_pfx[i] & prop_pfx[i - (1 << l)];
            end
        end

        carry_vec    = gen_pfx << 1;
        carry_vec[0] = cin;
        sum          = prop ^ carry_vec;
        cout         = gen_pfx[CHUNK-1];
    end

endmodule

// File: rtl/multiprecision_chunk_adder.sv
// Sequential WIDTH-bit adder: one CHUNK-bit slice per cycle, carry rippled through a register.
// Latency: NUM_CHUNKS cycles from accept edge to out_valid; one op per NUM_CHUNKS+2 cycles.
// Backpressure: result held stable in DONE until out_ready; no new operands accepted until then.
//
// Ports:
//   clk, rst              - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     - operand handshake (in_ready only in IDLE and not in reset)
//   in_a, in_b, in_cin    - operands and carry into bit 0, sampled on accept only
//   out_valid/out_ready   - result handshake
//   out_sum, out_cout     - a + b + cin (low WIDTH bits) and carry out of bit WIDTH-1
//   busy                  - high whenever an operation is in flight or waiting to drain
module multiprecision_chunk_adder
    import chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
    localparam int IDX_W      = idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("multiprecision_chunk_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic              carry;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic              cout_reg;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_cout;
    logic              last_chunk;

    // Current slice selected by shifting rather than a variable part-select,
    // so the single-slice configuration has no out-of-range index.
    assign a_chunk    = CHUNK'(a_reg >> (int'(idx) * CHUNK));
    assign b_chunk    = CHUNK'(b_reg >> (int'(idx) * CHUNK));
    assign last_chunk = (idx == LAST_IDX);

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (last_chunk) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        carry <= in_cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    carry <= chunk_cout;
                    for (int k = 0; k < NUM_CHUNKS; k++) begin
                        if (idx == IDX_W'(k)) begin
                            sum_reg[k*CHUNK +: CHUNK] <= chunk_sum;
                        end
                    end
                    if (last_chunk) begin
                        cout_reg <= chunk_cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // sum_reg is only written in RUN, so it cannot change while out_valid is high.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign out_sum   = sum_reg;
    assign out_cout  = cout_reg;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_multiprecision_chunk_adder.sv
module tb_multiprecision_chunk_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_in_cin, a_out_valid, a_out_ready, a_out_cout, a_busy;
    logic [31:0] a_in_a, a_in_b, a_out_sum;
    logic        b_in_valid, b_in_ready, b_in_cin, b_out_valid, b_out_ready, b_out_cout, b_busy;
    logic [15:0] b_in_a, b_in_b, b_out_sum;

    multiprecision_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_a(a_in_a), .in_b(a_in_b), .in_cin(a_in_cin),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_cout(a_out_cout), .busy(a_busy)
    );

    multiprecision_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_cin(b_in_cin),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_cout(b_out_cout), .busy(b_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit rnd_done;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Expected result of one accepted operation and the cycle count just after its accept edge.
    typedef struct {
        logic [31:0] s;
        logic        c;
        int          acc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Reference behaviour: an operation accepted at edge E0 has its result presented from
    // NUM_CHUNKS cycles later until consumed; the unit is idle exactly when nothing is pending.
    always @(negedge clk) begin : mon_a
        logic        ev;
        logic [32:0] t;
        if (rst) begin
            qa.delete();
            chk("a_in_ready_in_reset", a_in_ready, 0);
        end else begin
            ev = 1'b0;
            if (qa.size() > 0) ev = ((cyc - qa[0].acc) >= 4);
            chk("a_busy", a_busy, qa.size() != 0);
            chk("a_in_ready", a_in_ready, qa.size() == 0);
            chk("a_out_valid", a_out_valid, ev);
            if (a_out_valid && ev) begin
                chk("a_out_sum", a_out_sum, qa[0].s);
                chk("a_out_cout", a_out_cout, qa[0].c);
                if (a_out_ready) void'(qa.pop_front());
            end
            if (a_in_valid && a_in_ready) begin
                t = {1'b0, a_in_a} + {1'b0, a_in_b} + 33'(a_in_cin);
                qa.push_back('{s: t[31:0], c: t[32], acc: cyc + 1});
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic        ev;
        logic [16:0] t;
        if (rst) begin
            qb.delete();
            chk("b_in_ready_in_reset", b_in_ready, 0);
        end else begin
            ev = 1'b0;
            if (qb.size() > 0) ev = ((cyc - qb[0].acc) >= 1);
            chk("b_busy", b_busy, qb.size() != 0);
            chk("b_in_ready", b_in_ready, qb.size() == 0);
            chk("b_out_valid", b_out_valid, ev);
            if (b_out_valid && ev) begin
                chk("b_out_sum", b_out_sum, qb[0].s);
                chk("b_out_cout", b_out_cout, qb[0].c);
                if (b_out_ready) void'(qb.pop_front());
            end
            if (b_in_valid && b_in_ready) begin
                t = {1'b0, b_in_a} + {1'b0, b_in_b} + 17'(b_in_cin);
                qb.push_back('{s: {16'h0, t[15:0]}, c: t[16], acc: cyc + 1});
            end
        end
    end

    // Drivers are entered and left just after a rising edge.
    task automatic send_a(input logic [31:0] a, input logic [31:0] b, input logic c);
        int n;
        a_in_a = a; a_in_b = b; a_in_cin = c; a_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!a_in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("a_accept_timeout", n, 0);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] a, input logic [15:0] b, input logic c);
        int n;
        b_in_a = a; b_in_b = b; b_in_cin = c; b_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b_in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("b_accept_timeout", n, 0);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    // Sends one op, counts edges until out_valid, then checks hand-computed literals.
    // Returns at the falling edge where out_valid was first seen.
    task automatic op_a(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [31:0] es, input logic ec, input string nm);
        int n;
        send_a(a, b, c);
        n = 0;
        @(negedge clk);
        while (!a_out_valid && n < 50) begin @(posedge clk); n++; @(negedge clk); end
        chk({nm, "_latency"}, n, 4);
        chk({nm, "_sum"}, a_out_sum, es);
        chk({nm, "_cout"}, a_out_cout, ec);
    endtask

    task automatic op_b(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] es, input logic ec, input string nm);
        int n;
        send_b(a, b, c);
        n = 0;
        @(negedge clk);
        while (!b_out_valid && n < 50) begin @(posedge clk); n++; @(negedge clk); end
        chk({nm, "_latency"}, n, 1);
        chk({nm, "_sum"}, b_out_sum, es);
        chk({nm, "_cout"}, b_out_cout, ec);
    endtask

    task automatic drain(input bit use_a);
        int n;
        n = 0;
        while ((use_a ? qa.size() : qb.size()) != 0 && n < 200) begin @(posedge clk); n++; end
        chk(use_a ? "a_drain" : "b_drain", use_a ? qa.size() : qb.size(), 0);
        #1;
    endtask

    task automatic rand_run(input bit use_a, input int nops);
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < nops; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    if (use_a) send_a($urandom, $urandom, 1'($urandom_range(0, 1)));
                    else       send_b(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    if (use_a) a_out_ready = ($urandom_range(0, 3) != 0);
                    else       b_out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        drain(use_a);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          acc [3];
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic        vc [3];

        rst = 1'b1;
        a_in_valid = 0; a_in_a = 0; a_in_b = 0; a_in_cin = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_in_cin = 0; b_out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_sum", a_out_sum, 0);
        chk("rst_out_cout", a_out_cout, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_b_out_sum", b_out_sum, 0);
        @(posedge clk); #1;

        // Full carry ripple through every chunk.
        op_a(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "t1");
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_valid_one_cycle", a_out_valid, 0);
        @(posedge clk); #1;

        op_a(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, "t2");
        @(posedge clk); #1;

        // Backpressure: result held, in_valid ignored while not idle.
        a_out_ready = 1'b0;
        op_a(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, "t3");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            a_in_valid = (i == 0);
            a_in_a = 32'd1; a_in_b = 32'd1; a_in_cin = 1'b0;
            @(negedge clk);
            chk("t3_hold_valid", a_out_valid, 1);
            chk("t3_hold_sum", a_out_sum, 32'h0001_0000);
            chk("t3_hold_cout", a_out_cout, 0);
            chk("t3_hold_in_ready", a_in_ready, 0);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_in_ready_after", a_in_ready, 1);
        chk("t3_valid_after", a_out_valid, 0);
        @(posedge clk); #1;

        // Reset while the third chunk is being added.
        send_a(32'h1111_1111, 32'h2222_2222, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_valid", a_out_valid, 0);
        chk("t4_sum", a_out_sum, 0);
        chk("t4_cout", a_out_cout, 0);
        chk("t4_busy", a_busy, 0);
        @(posedge clk); #1;
        op_a(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, "t4b");
        @(posedge clk); #1;

        // Back-to-back with in_valid and out_ready held high.
        va[0] = 32'hDEAD_BEEF; vb[0] = 32'h0123_4567; vc[0] = 1'b1;
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF; vc[1] = 1'b1;
        va[2] = 32'h0F0F_0F0F; vb[2] = 32'hF0F0_F0F0; vc[2] = 1'b1;
        a_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_in_a = va[k]; a_in_b = vb[k]; a_in_cin = vc[k];
            n = 0;
            @(negedge clk);
            while (!a_in_ready && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) chk("t5_accept_timeout", n, 0);
            acc[k] = cyc + 1;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        chk("t5_spacing_01", acc[1] - acc[0], 6);
        chk("t5_spacing_12", acc[2] - acc[1], 6);
        drain(1'b1);

        rand_run(1'b1, 1000);

        // Single-chunk configuration.
        op_b(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "b1");
        @(posedge clk); #1;
        op_b(16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, "b2");
        @(posedge clk); #1;

        rand_run(1'b0, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
